// File: rtl/memc_sgl_responder_pkg.sv
// -----------------------------------------------------------------------------
// memc_sgl_responder_pkg
// Shared types for the memory controller's single-access (uncached/MMIO) path:
//   MemC_Cmd               memory controller command encoding
//   MemController_Req      request from the load/store side
//   MemController_SglLdRes single-access load result {valid, data}
//   MemController_SglStRes single-access store completion {valid}
//   SglBus_Req/SglBus_Res  external single-access bus request/response bundles
//   sgl_state_e            responder FSM states
// Helper functions classify commands as reads/writes and give the access size.
// -----------------------------------------------------------------------------
package memc_sgl_responder_pkg;

    typedef enum logic [3:0] {
        MEMC_NONE            = 4'd0,
        MEMC_REPLACE         = 4'd1,
        MEMC_CP_CACHE_TO_EXT = 4'd2,
        MEMC_CP_EXT_TO_CACHE = 4'd3,
        MEMC_READ_BYTE       = 4'd4,
        MEMC_READ_HALF       = 4'd5,
        MEMC_READ_WORD       = 4'd6,
        MEMC_WRITE_BYTE      = 4'd7,
        MEMC_WRITE_HALF      = 4'd8,
        MEMC_WRITE_WORD      = 4'd9
    } MemC_Cmd;

    typedef struct packed {
        MemC_Cmd     cmd;
        logic [31:0] readAddr;
        logic [31:0] writeAddr;
        logic [31:0] data;
        logic [1:0]  cacheID;
        logic [2:0]  sqID;
    } MemController_Req;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } MemController_SglLdRes;

    typedef struct packed {
        logic valid;
    } MemController_SglStRes;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } SglBus_Req;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
    } SglBus_Res;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } sgl_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } sgl_state_e;

    function automatic logic is_sgl_read(MemC_Cmd c);
        return (c == MEMC_READ_BYTE) || (c == MEMC_READ_HALF) || (c == MEMC_READ_WORD);
    endfunction

    function automatic logic is_sgl_write(MemC_Cmd c);
        return (c == MEMC_WRITE_BYTE) || (c == MEMC_WRITE_HALF) || (c == MEMC_WRITE_WORD);
    endfunction

    function automatic sgl_size_e sgl_size(MemC_Cmd c);
        case (c)
            MEMC_READ_BYTE, MEMC_WRITE_BYTE: return SZ_BYTE;
            MEMC_READ_HALF, MEMC_WRITE_HALF: return SZ_HALF;
            default:                         return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/memc_sgl_responder_if.sv
// -----------------------------------------------------------------------------
// memc_sgl_responder_if
// External single-access valid/ready bus.
//   bus_valid  request valid             (master -> slave)
//   bus_ready  request accepted          (slave  -> master)
//   bus_we     1 = write                 (master -> slave)
//   bus_addr   word-aligned address      (master -> slave)
//   bus_wdata  write data, unshifted     (master -> slave)
//   bus_wstrb  byte strobes              (master -> slave)
//   bus_rvalid response valid, rd and wr (slave  -> master)
//   bus_rdata  read data, full word      (slave  -> master)
// Modports: master (memory controller side), slave (external device side).
// -----------------------------------------------------------------------------
interface memc_sgl_responder_if #(
    parameter int ADDR_W = 32
) ();
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_wstrb;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/memc_sgl_responder_lane_align.sv
// -----------------------------------------------------------------------------
// memc_sgl_lane_align (combinational)
// Maps a single-access command and the low address bits to byte strobes, and
// right-aligns a full read word into a byte/half/word result.
//   i_cmd         command (size taken from it)
//   i_addr_lo     address bits [1:0]
//   i_rdata       full read word from the bus
//   o_wstrb       byte strobes
//   o_rdata       zero-extended, right-aligned read data
//   o_misaligned  half with a[0]=1, or word with a[1:0]!=0
// -----------------------------------------------------------------------------
module memc_sgl_lane_align
    import memc_sgl_responder_pkg::*;
(
    input  MemC_Cmd     i_cmd,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);
    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;

    assign w_byte_sh = i_rdata >> {i_addr_lo, 3'b000};
    assign w_half_sh = i_rdata >> {i_addr_lo[1], 4'b0000};

    always_comb begin
        o_wstrb      = 4'b1111;
        o_rdata      = i_rdata;
        o_misaligned = 1'b0;
        case (sgl_size(i_cmd))
            SZ_BYTE: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_rdata = {24'b0, w_byte_sh[7:0]};
            end
            SZ_HALF: begin
                // a[0] is dropped: the half sits in the lane pair picked by a[1]
                o_wstrb      = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_rdata      = {16'b0, w_half_sh[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_misaligned = (i_addr_lo != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/memc_sgl_responder.sv
// -----------------------------------------------------------------------------
// memc_sgl_responder
// Memory-controller end of the single-access channel. Takes one read/write
// request at a time, drives it onto the external valid/ready bus, and returns
// a one-cycle load result or store completion. OUT_stall is high while busy.
//   clk, rst       clock, asynchronous active-high reset
//   IN_req         request (cmd, readAddr, writeAddr, data used)
//   OUT_stall      1 = request not accepted this cycle
//   OUT_sglLdRes   load result pulse {valid, data}
//   OUT_sglStRes   store completion pulse {valid}
//   bus            external bus, master modport
// Optional build macro: MEMC_SGL_TIMEOUT_EN adds a watchdog (parameter TIMEOUT)
// that forces completion after TIMEOUT cycles in REQ/RSP; reads then return
// 32'hFFFF_FFFF. Without it the FSM waits indefinitely.
//
// state | meaning
// IDLE  | waiting for a read/write command
// REQ   | bus_valid high, waiting for bus_ready
// RSP   | waiting for bus_rvalid
// DONE  | one-cycle result pulse, back to IDLE
// -----------------------------------------------------------------------------
module memc_sgl_responder
    import memc_sgl_responder_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef MEMC_SGL_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  MemController_Req      IN_req,
    output logic                  OUT_stall,
    output MemController_SglLdRes OUT_sglLdRes,
    output MemController_SglStRes OUT_sglStRes,
    memc_sgl_responder_if.master  bus
);
    sgl_state_e        r_state;
    sgl_state_e        w_state_nxt;
    MemC_Cmd           r_cmd;
    logic [1:0]        r_addr_lo;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_rdata;

    logic              w_is_rd;
    logic              w_is_wr;
    logic              w_accept;
    logic [31:0]       w_req_addr;
    SglBus_Res         w_bus_res;
    MemC_Cmd           w_al_cmd;
    logic [1:0]        w_al_lo;
    logic [3:0]        w_al_wstrb;
    logic [31:0]       w_al_rdata;
    logic              w_al_misaligned;
    logic              w_timeout;
    logic              w_unused_req;

    assign w_unused_req = ^{IN_req.cacheID, IN_req.sqID};

    assign w_is_rd    = is_sgl_read(IN_req.cmd);
    assign w_is_wr    = is_sgl_write(IN_req.cmd);
    assign w_accept   = (r_state == IDLE) && (w_is_rd || w_is_wr);
    assign w_req_addr = w_is_wr ? IN_req.writeAddr : IN_req.readAddr;
    assign w_bus_res  = '{rvalid: bus.bus_rvalid, rdata: bus.bus_rdata};

    // One aligner serves both ends: the incoming request while IDLE (strobes),
    // the latched request afterwards (read data).
    assign w_al_cmd = (r_state == IDLE) ? IN_req.cmd      : r_cmd;
    assign w_al_lo  = (r_state == IDLE) ? w_req_addr[1:0] : r_addr_lo;

    memc_sgl_lane_align u_lane_align (
        .i_cmd        (w_al_cmd),
        .i_addr_lo    (w_al_lo),
        .i_rdata      (w_bus_res.rdata),
        .o_wstrb      (w_al_wstrb),
        .o_rdata      (w_al_rdata),
        .o_misaligned (w_al_misaligned)
    );

`ifdef MEMC_SGL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == REQ) || (r_state == RSP)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = ((r_state == REQ) || (r_state == RSP)) &&
                       (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        OUT_stall          = (r_state != IDLE);
        bus.bus_valid      = 1'b0;
        OUT_sglLdRes.valid = 1'b0;
        OUT_sglLdRes.data  = r_rdata;
        OUT_sglStRes.valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                bus.bus_valid = 1'b1;
                if (w_timeout) begin
                    w_state_nxt = DONE;
                end else if (bus.bus_ready) begin
                    w_state_nxt = RSP;
                end
            end
            RSP: begin
                if (w_bus_res.rvalid || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                OUT_sglLdRes.valid = ~r_we;
                OUT_sglStRes.valid = r_we;
                w_state_nxt        = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd     <= MEMC_NONE;
            r_addr_lo <= 2'b00;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_cmd     <= IN_req.cmd;
                r_addr_lo <= w_req_addr[1:0];
                r_we      <= w_is_wr;
                r_addr    <= {w_req_addr[ADDR_W-1:2], 2'b00};
                r_wdata   <= IN_req.data;
                r_wstrb   <= w_al_wstrb;
            end
            // A real response wins over a watchdog expiry in the same cycle.
            if ((r_state == RSP) && w_bus_res.rvalid) begin
                if (!r_we) begin
                    r_rdata <= w_al_rdata;
                end
            end else if (w_timeout && !r_we) begin
                r_rdata <= 32'hFFFF_FFFF;
            end
        end
    end

    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign bus.bus_wstrb = r_wstrb;

`ifndef SYNTHESIS
    // The requester is expected to issue naturally aligned half/word accesses.
    a_aligned_access: assert property (@(posedge clk) disable iff (rst)
        w_accept |-> !w_al_misaligned);
`endif

endmodule

// File: tb/tb_memc_sgl_responder.sv
module tb_memc_sgl_responder;
    import memc_sgl_responder_pkg::*;

    localparam int ADDR_W = 32;
`ifdef MEMC_SGL_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    MemController_Req      req;
    logic                  stall;
    MemController_SglLdRes ld_res;
    MemController_SglStRes st_res;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_ld;

    memc_sgl_responder_if #(.ADDR_W(ADDR_W)) bus_if ();

    memc_sgl_responder #(
        .ADDR_W (ADDR_W)
`ifdef MEMC_SGL_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_req       (req),
        .OUT_stall    (stall),
        .OUT_sglLdRes (ld_res),
        .OUT_sglStRes (st_res),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int m_bytes(MemC_Cmd c);
        case (c)
            MEMC_READ_BYTE, MEMC_WRITE_BYTE: return 1;
            MEMC_READ_HALF, MEMC_WRITE_HALF: return 2;
            default:                         return 4;
        endcase
    endfunction

    function automatic logic m_is_write(MemC_Cmd c);
        return (c == MEMC_WRITE_BYTE) || (c == MEMC_WRITE_HALF) || (c == MEMC_WRITE_WORD);
    endfunction

    // byte offset of the access inside its word: address mod 4 rounded down to the size
    function automatic int m_off(MemC_Cmd c, logic [31:0] a);
        int n;
        n = m_bytes(c);
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] m_strb(MemC_Cmd c, logic [31:0] a);
        int s;
        s = ((1 << m_bytes(c)) - 1) << m_off(c, a);
        return 4'(s);
    endfunction

    function automatic logic [31:0] m_ld(MemC_Cmd c, logic [31:0] a, logic [31:0] rd);
        logic [63:0] w;
        w = 64'(rd) >> (8 * m_off(c, a));
        w = w & ((64'd1 << (8 * m_bytes(c))) - 64'd1);
        return w[31:0];
    endfunction

    function automatic logic [31:0] m_rand_addr(MemC_Cmd c);
        logic [31:0] a;
        a = $urandom();
        return a & ~32'(m_bytes(c) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. Called at edge+1 with the DUT idle. The bus holds
    // ready low for rdy_dly cycles and rvalid low for rv_dly cycles of RSP; while
    // busy, other requests are offered and must be refused.
    task automatic run_txn(input string tag, input MemC_Cmd cmd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int rdy_dly, input int rv_dly);
        logic        is_wr;
        int          t_done;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_ld;
        is_wr    = m_is_write(cmd);
        exp_addr = addr & ~32'h3;
        exp_strb = m_strb(cmd, addr);
        exp_ld   = m_ld(cmd, addr, rdata);
        t_done   = 3 + rdy_dly + rv_dly;

        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_stall got=%b exp=0", tag, stall);
        end
        n_checks++;
        if (ld_res.valid !== 1'b0 || st_res.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_result got=%b%b exp=00", tag, ld_res.valid, st_res.valid);
        end

        req.cmd       = cmd;
        req.readAddr  = is_wr ? $urandom() : addr;
        req.writeAddr = is_wr ? addr : $urandom();
        req.data      = wdata;
        req.cacheID   = 2'($urandom());
        req.sqID      = 3'($urandom());
        bus_if.bus_ready  = 1'($urandom_range(0, 1));
        bus_if.bus_rvalid = 1'($urandom_range(0, 1));
        bus_if.bus_rdata  = $urandom();
        tick();

        for (int cyc = 1; cyc <= t_done; cyc++) begin
            n_checks++;
            if (stall !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_stall cyc=%0d got=%b exp=1", tag, cyc, stall);
            end
            n_checks++;
            if (bus_if.bus_valid !== (cyc <= rdy_dly + 1)) begin
                n_fail++;
                $display("FAIL %s bus_valid cyc=%0d got=%b exp=%b", tag, cyc,
                         bus_if.bus_valid, (cyc <= rdy_dly + 1));
            end
            if (cyc <= rdy_dly + 1) begin
                n_checks++;
                if (bus_if.bus_addr !== exp_addr || bus_if.bus_wstrb !== exp_strb ||
                    bus_if.bus_we !== is_wr || (is_wr && bus_if.bus_wdata !== wdata)) begin
                    n_fail++;
                    $display("FAIL %s bus_fields cyc=%0d got addr=%h strb=%b we=%b wdata=%h exp addr=%h strb=%b we=%b wdata=%h",
                             tag, cyc, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_we, bus_if.bus_wdata,
                             exp_addr, exp_strb, is_wr, wdata);
                end
            end
            n_checks++;
            if (ld_res.valid !== (cyc == t_done && !is_wr)) begin
                n_fail++;
                $display("FAIL %s ld_valid cyc=%0d got=%b exp=%b", tag, cyc, ld_res.valid,
                         (cyc == t_done && !is_wr));
            end
            n_checks++;
            if (st_res.valid !== (cyc == t_done && is_wr)) begin
                n_fail++;
                $display("FAIL %s st_valid cyc=%0d got=%b exp=%b", tag, cyc, st_res.valid,
                         (cyc == t_done && is_wr));
            end
            if (cyc == t_done && !is_wr) begin
                last_ld = ld_res.data;
                n_checks++;
                if (ld_res.data !== exp_ld) begin
                    n_fail++;
                    $display("FAIL %s ld_data got=%h exp=%h", tag, ld_res.data, exp_ld);
                end
            end

            req.cmd       = MemC_Cmd'($urandom_range(0, 9));
            req.readAddr  = $urandom() & ~32'h3;
            req.writeAddr = $urandom() & ~32'h3;
            req.data      = $urandom();
            if (cyc <= rdy_dly + 1) bus_if.bus_ready = (cyc == rdy_dly + 1);
            else                    bus_if.bus_ready = 1'($urandom_range(0, 1));
            if (cyc >= rdy_dly + 2 && cyc <= t_done - 1) bus_if.bus_rvalid = (cyc == t_done - 1);
            else                                         bus_if.bus_rvalid = 1'($urandom_range(0, 1));
            bus_if.bus_rdata = (cyc == t_done - 1) ? rdata : $urandom();
            tick();
        end
        req.cmd           = MEMC_NONE;
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_checks++;
        if (bus_if.bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bus_valid got=%b exp=0", bus_if.bus_valid); end
        n_checks++;
        if (bus_if.bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we got=%b exp=0", bus_if.bus_we); end
        n_checks++;
        if (bus_if.bus_addr !== '0 || bus_if.bus_wdata !== '0 || bus_if.bus_wstrb !== '0) begin
            n_fail++;
            $display("FAIL reset_bus_fields got addr=%h wdata=%h strb=%b exp all zero",
                     bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb);
        end
        n_checks++;
        if (ld_res.valid !== 1'b0 || st_res.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_results got=%b%b exp=00", ld_res.valid, st_res.valid);
        end
    endtask

    task automatic test_ignored_cmds();
        for (int i = 0; i < 8; i++) begin
            req.cmd           = MemC_Cmd'($urandom_range(0, 3));
            req.readAddr      = $urandom();
            req.writeAddr     = $urandom();
            bus_if.bus_ready  = 1'($urandom_range(0, 1));
            bus_if.bus_rvalid = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (stall !== 1'b0 || bus_if.bus_valid !== 1'b0 || ld_res.valid !== 1'b0 || st_res.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ignored_cmd i=%0d got stall=%b valid=%b ld=%b st=%b exp all 0",
                         i, stall, bus_if.bus_valid, ld_res.valid, st_res.valid);
            end
        end
        req.cmd           = MEMC_NONE;
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
    endtask

    task automatic test_directed();
        last_ld = 'x;
        run_txn("rd_word", MEMC_READ_WORD, 32'h1000_0004, $urandom(), 32'hDEAD_BEEF, 0, 0);
        n_checks++;
        if (last_ld !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_word_value got=%h exp=deadbeef", last_ld); end
        last_ld = 'x;
        run_txn("rd_byte", MEMC_READ_BYTE, 32'h1000_0003, $urandom(), 32'hAABB_CCDD, 0, 1);
        n_checks++;
        if (last_ld !== 32'h0000_00AA) begin n_fail++; $display("FAIL rd_byte_value got=%h exp=000000aa", last_ld); end
        last_ld = 'x;
        run_txn("rd_half", MEMC_READ_HALF, 32'h1000_0002, $urandom(), 32'hAABB_CCDD, 1, 0);
        n_checks++;
        if (last_ld !== 32'h0000_AABB) begin n_fail++; $display("FAIL rd_half_value got=%h exp=0000aabb", last_ld); end
        run_txn("wr_byte", MEMC_WRITE_BYTE, 32'h1000_0001, 32'h0000_5500, $urandom(), 0, 0);
    endtask

    task automatic test_stall();
        run_txn("stall_wr", MEMC_WRITE_HALF, 32'h2000_0006, 32'h1234_5678, $urandom(), 5, 2);
        run_txn("stall_rd", MEMC_READ_WORD, 32'h2000_0008, $urandom(), $urandom(), 5, 3);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            MemC_Cmd c;
            c = MemC_Cmd'($urandom_range(4, 9));
            run_txn("rand", c, m_rand_addr(c), $urandom(), $urandom(),
                    $urandom_range(0, 4), $urandom_range(0, 4));
        end
    endtask

    task automatic test_reset_mid();
        req.cmd       = MEMC_WRITE_WORD;
        req.writeAddr = 32'h3000_0040;
        req.readAddr  = '0;
        req.data      = 32'hCAFE_F00D;
        tick();
        req.cmd          = MEMC_NONE;
        bus_if.bus_ready = 1'b1;
        tick();
        bus_if.bus_ready = 1'b0;
        n_checks++;
        if (stall !== 1'b1 || bus_if.bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_in_rsp got stall=%b valid=%b exp stall=1 valid=0", stall, bus_if.bus_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0 || bus_if.bus_valid !== 1'b0 || bus_if.bus_we !== 1'b0 ||
            bus_if.bus_addr !== '0 || bus_if.bus_wdata !== '0 || bus_if.bus_wstrb !== '0 ||
            ld_res.valid !== 1'b0 || st_res.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got stall=%b valid=%b we=%b addr=%h wdata=%h strb=%b ld=%b st=%b exp all 0",
                     stall, bus_if.bus_valid, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata,
                     bus_if.bus_wstrb, ld_res.valid, st_res.valid);
        end
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_ready  = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (stall !== 1'b0 || ld_res.valid !== 1'b0 || st_res.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_no_result i=%0d got stall=%b ld=%b st=%b exp 0", i,
                         stall, ld_res.valid, st_res.valid);
            end
        end
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_ready  = 1'b0;
    endtask

`ifdef MEMC_SGL_TIMEOUT_EN
    task automatic test_timeout();
        for (int k = 0; k < 2; k++) begin
            logic is_wr;
            is_wr         = (k == 1);
            req.cmd       = is_wr ? MEMC_WRITE_WORD : MEMC_READ_WORD;
            req.readAddr  = 32'h4000_0010;
            req.writeAddr = 32'h4000_0010;
            req.data      = $urandom();
            bus_if.bus_ready  = 1'b0;
            bus_if.bus_rvalid = 1'b0;
            tick();
            req.cmd = MEMC_NONE;
            for (int cyc = 1; cyc <= TIMEOUT + 1; cyc++) begin
                n_checks++;
                if (bus_if.bus_valid !== (is_wr ? (cyc <= TIMEOUT) : (cyc == 1))) begin
                    n_fail++;
                    $display("FAIL tmo_bus_valid k=%0d cyc=%0d got=%b", k, cyc, bus_if.bus_valid);
                end
                n_checks++;
                if (ld_res.valid !== (!is_wr && cyc == TIMEOUT + 1) ||
                    st_res.valid !== (is_wr && cyc == TIMEOUT + 1)) begin
                    n_fail++;
                    $display("FAIL tmo_result k=%0d cyc=%0d got ld=%b st=%b", k, cyc, ld_res.valid, st_res.valid);
                end
                if (!is_wr && cyc == TIMEOUT + 1) begin
                    n_checks++;
                    if (ld_res.data !== 32'hFFFF_FFFF) begin
                        n_fail++;
                        $display("FAIL tmo_ld_data got=%h exp=ffffffff", ld_res.data);
                    end
                end
                bus_if.bus_ready = is_wr ? 1'b0 : (cyc == 1);
                tick();
            end
            bus_if.bus_ready  = 1'b1;
            bus_if.bus_rvalid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (stall !== 1'b0 || bus_if.bus_valid !== 1'b0 || ld_res.valid !== 1'b0 || st_res.valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tmo_late_rsp k=%0d i=%0d got stall=%b valid=%b ld=%b st=%b exp 0",
                             k, i, stall, bus_if.bus_valid, ld_res.valid, st_res.valid);
                end
                tick();
            end
            bus_if.bus_ready  = 1'b0;
            bus_if.bus_rvalid = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ignored_cmds();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef MEMC_SGL_TIMEOUT_EN
        test_timeout();
`endif
        run_txn("after_all", MEMC_READ_HALF, 32'h5000_0000, $urandom(), 32'h1122_3344, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
